// File: rtl/inv_factorial_pkg.sv
// Shared definitions for the factorial / inverse-factorial pair:
// FSM state encodings and the default operand widths.
package inv_factorial_pkg;

   localparam int DEF_N_WIDTH  = 8;
   localparam int DEF_FN_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/inv_factorial_if.sv
// Start/done request bus of the inverse-factorial engine.
// The requester drives start/fn; the engine returns done/n/exact.
interface inv_factorial_if #(
   parameter int N_WIDTH  = 8,
   parameter int FN_WIDTH = 32
);
   logic                start;
   logic [FN_WIDTH-1:0] fn;
   logic                done;
   logic [N_WIDTH-1:0]  n;
   logic                exact;

   modport master (output start, fn, input done, n, exact);
   modport slave  (input start, fn, output done, n, exact);
endinterface

// File: rtl/inv_factorial_mul_ovf_chk.sv
// Combinational FN_WIDTH x N_WIDTH multiplier: truncated product plus a flag
// raised when any bit of the full product lies above FN_WIDTH.
module mul_ovf_chk #(
   parameter int FN_WIDTH = 32,
   parameter int N_WIDTH  = 8
) (
   input  logic [FN_WIDTH-1:0] a_i,
   input  logic [N_WIDTH-1:0]  b_i,
   output logic [FN_WIDTH-1:0] prod_o,
   output logic                ovf_o
);
   logic [FN_WIDTH+N_WIDTH-1:0] full;

   assign full   = {{N_WIDTH{1'b0}}, a_i} * {{FN_WIDTH{1'b0}}, b_i};
   assign prod_o = full[FN_WIDTH-1:0];
   assign ovf_o  = |full[FN_WIDTH+N_WIDTH-1:FN_WIDTH];
endmodule

// File: rtl/inv_factorial.sv
// Inverse factorial: finds the largest k >= 1 with k! <= fn, one
// multiply-and-compare step per clock, and flags whether fn is exactly k!.
module inv_factorial
   import inv_factorial_pkg::*;
#(
   parameter int N_WIDTH  = DEF_N_WIDTH,
   parameter int FN_WIDTH = DEF_FN_WIDTH
) (
   input logic            clk,
   input logic            rst,
   inv_factorial_if.slave bus
);
   state_e              state_q, state_d;
   logic [FN_WIDTH-1:0] target_q, target_d;
   logic [FN_WIDTH-1:0] acc_q, acc_d;
   logic [N_WIDTH-1:0]  k_q, k_d;
   logic                done_q, done_d;
   logic [N_WIDTH-1:0]  n_q, n_d;
   logic                exact_q, exact_d;

   logic [N_WIDTH-1:0]  k_plus1;
   logic [FN_WIDTH-1:0] prod;
   logic                prod_ovf;
   logic                accept;
   logic                reached;

   assign k_plus1 = k_q + N_WIDTH'(1);
   assign accept  = (state_q == ST_IDLE || state_q == ST_DONE) && bus.start;
   assign reached = (acc_q >= target_q);

   mul_ovf_chk #(
      .FN_WIDTH(FN_WIDTH),
      .N_WIDTH (N_WIDTH)
   ) u_mul (
      .a_i   (acc_q),
      .b_i   (k_plus1),
      .prod_o(prod),
      .ovf_o (prod_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         done_q   <= 1'b0;
         n_q      <= '0;
         exact_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         done_q   <= done_d;
         n_q      <= n_d;
         exact_q  <= exact_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (reached || prod_ovf) state_d = ST_DONE;
         ST_DONE: if (bus.start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and result registers; a reached target takes priority over overflow.
   always_comb begin
      target_d = target_q;
      acc_d    = acc_q;
      k_d      = k_q;
      done_d   = done_q;
      n_d      = n_q;
      exact_d  = exact_q;
      if (accept) begin
         target_d = bus.fn;
         acc_d    = FN_WIDTH'(1);
         k_d      = N_WIDTH'(1);
         done_d   = 1'b0;
         n_d      = '0;
         exact_d  = 1'b0;
      end else if (state_q == ST_RUN) begin
         if (reached) begin
            done_d = 1'b1;
            if (acc_q == target_q) begin
               n_d     = k_q;
               exact_d = 1'b1;
            end else begin
               n_d     = k_q - N_WIDTH'(1);
               exact_d = 1'b0;
            end
         end else if (prod_ovf) begin
            done_d  = 1'b1;
            n_d     = k_q;
            exact_d = 1'b0;
         end else begin
            acc_d = prod;
            k_d   = k_plus1;
         end
      end
   end

   assign bus.done  = done_q;
   assign bus.n     = n_q;
   assign bus.exact = exact_q;
endmodule

// File: tb/tb_inv_factorial.sv
// Self-checking bench for inv_factorial against a plain-arithmetic model.
module tb_inv_factorial;
   localparam int NW = 8;
   localparam int FW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   inv_factorial_if #(.N_WIDTH(NW), .FN_WIDTH(FW)) bus ();

   inv_factorial #(.N_WIDTH(NW), .FN_WIDTH(FW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference: largest k with k! <= fn, exactness, and cycles to done.
   function automatic void model(input logic [31:0] fn, output int en, output bit ex,
                                 output int lat);
      longint unsigned f = 1;
      int k = 1;
      if (fn == 0) begin
         en = 0; ex = 0; lat = 1;
         return;
      end
      while (f * longint'(k + 1) <= longint'(fn)) begin
         f = f * longint'(k + 1);
         k++;
      end
      en = k;
      ex = (f == longint'(fn));
      if (ex) lat = k;
      else if (f * longint'(k + 1) > 64'hFFFF_FFFF) lat = k;
      else lat = k + 1;
   endfunction

   function automatic logic [31:0] fact(input int k);
      longint unsigned f = 1;
      for (int i = 2; i <= k; i++) f = f * longint'(i);
      return f[31:0];
   endfunction

   task automatic launch(input logic [31:0] v);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.fn    = v;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.fn    = $urandom;
   endtask

   // Counts edges after the start edge until done rises; to=1 if the budget runs out.
   task automatic wait_done(output int lat, output bit to);
      lat = 1;
      to  = 1'b0;
      while (!bus.done) begin
         if (lat >= 40) begin
            to = 1'b1;
            return;
         end
         @(posedge clk); #1;
         lat++;
      end
      lat = lat - 1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.fn = 32'd6;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if ({bus.done, bus.n, bus.exact} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got done=%0b n=%0d exact=%0b, want all 0",
                  bus.done, bus.n, bus.exact);
      end
      bus.start = 1'b0;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus.done !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_no_done: got done=%0b, want 0", bus.done);
      end
   endtask

   task automatic run_one(input string name, input logic [31:0] v);
      int en, lat, dl;
      bit ex, to;
      model(v, en, ex, lat);
      launch(v);
      @(posedge clk); #1;
      wait_done(dl, to);
      dl = dl + 1;
      vec_cnt++;
      if (to || bus.n !== NW'(en) || bus.exact !== ex || dl != lat) begin
         err_cnt++;
         $display("FAIL %s fn=%0d: got n=%0d exact=%0b lat=%0d to=%0b, want n=%0d exact=%0b lat=%0d",
                  name, v, bus.n, bus.exact, dl, to, en, ex, lat);
      end
   endtask

   task automatic test_exact_hold;
      run_one("exact_10", 32'd3628800);
      repeat (5) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus.done !== 1'b1 || bus.n !== 8'd10 || bus.exact !== 1'b1) begin
         err_cnt++;
         $display("FAIL done_hold: got done=%0b n=%0d exact=%0b, want 1 10 1",
                  bus.done, bus.n, bus.exact);
      end
   endtask

   task automatic test_boundaries;
      run_one("nonexact_100", 32'd100);
      run_one("zero", 32'd0);
      run_one("one", 32'd1);
      run_one("two", 32'd2);
      run_one("overflow_max", 32'hFFFF_FFFF);
      run_one("exact_12", 32'd479001600);
      run_one("above_12", 32'd479001601);
   endtask

   task automatic test_back_to_back;
      run_one("b2b_first", 32'd6);
      launch(32'd120);
      vec_cnt++;
      if (bus.done !== 1'b0 || bus.n !== 8'd0 || bus.exact !== 1'b0) begin
         err_cnt++;
         $display("FAIL b2b_drop: got done=%0b n=%0d exact=%0b, want 0 0 0",
                  bus.done, bus.n, bus.exact);
      end
      begin
         int dl;
         bit to;
         wait_done(dl, to);
         vec_cnt++;
         if (to || bus.n !== 8'd5 || bus.exact !== 1'b1 || dl != 5) begin
            err_cnt++;
            $display("FAIL b2b_second: got n=%0d exact=%0b lat=%0d to=%0b, want 5 1 5",
                     bus.n, bus.exact, dl, to);
         end
      end
   endtask

   task automatic test_midrun_start_ignored;
      int cyc = 0;
      launch(32'd3628800);
      while (!bus.done && cyc < 40) begin
         cyc++;
         bus.start = (cyc == 3);
         bus.fn    = (cyc == 3) ? 32'd5 : 32'd0;
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      vec_cnt++;
      if (bus.done !== 1'b1 || bus.n !== 8'd10 || bus.exact !== 1'b1 || cyc != 10) begin
         err_cnt++;
         $display("FAIL midrun_start: got done=%0b n=%0d exact=%0b lat=%0d, want 1 10 1 10",
                  bus.done, bus.n, bus.exact, cyc);
      end
   endtask

   task automatic test_midrun_reset;
      launch(32'd3628800);
      for (int c = 1; c <= 6; c++) begin
         bus.start = (c == 3);
         bus.fn    = (c == 3) ? 32'd5 : 32'd0;
         rst       = (c == 6);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      rst = 1'b0;
      vec_cnt++;
      if ({bus.done, bus.n, bus.exact} !== '0) begin
         err_cnt++;
         $display("FAIL midrun_reset: got done=%0b n=%0d exact=%0b, want all 0",
                  bus.done, bus.n, bus.exact);
      end
      repeat (12) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus.done !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_abort_idle: got done=%0b, want 0", bus.done);
      end
      run_one("after_reset_24", 32'd24);
   endtask

   task automatic test_round_trip;
      for (int k = 1; k <= 12; k++) run_one("round_trip", fact(k));
   endtask

   task automatic test_random;
      logic [31:0] v;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 200);
            2: v = fact($urandom_range(1, 12)) + 32'($urandom_range(0, 2)) - 32'd1;
            default: v = $urandom_range(32'd479001600, 32'hFFFF_FFFF);
         endcase
         run_one("random", v);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.fn = '0;
      test_reset();
      test_exact_hold();
      test_boundaries();
      test_back_to_back();
      test_midrun_start_ignored();
      test_midrun_reset();
      test_round_trip();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/inv_factorial.md
Name: inv_factorial

Overview:
- Inverse of the factorial engine: given a value `fn`, finds the largest `k >= 1` with `k! <= fn` and flags whether `fn` is exactly `k!`.
- Uses the same start/done handshake and the same `N_WIDTH`/`FN_WIDTH` pairing as the factorial block.
- Sits beside the factorial block so that a round-trip check (`n` -> `fn` -> `n`) runs in one bench.
- Iterative: one multiply-and-compare step per clock.

Parameters:
- `N_WIDTH`, 8: width of the result `n` and of the internal step counter. Must hold `max_n + 1` for the chosen `FN_WIDTH`.
- `FN_WIDTH`, 32: width of the `fn` operand and of the running product.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `fn`  input  `FN_WIDTH`  value to invert; captured on the start edge.
- `done`  output  1  level-high while a result is valid.
- `n`  output  `N_WIDTH`  largest `k >= 1` with `k! <= fn`; 0 when `fn` = 0.
- `exact`  output  1  1 when `fn == n!`.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; `done`=0, `n`=0, `exact`=0; internal target, `acc` and `k` cleared.
- Reset mid-operation aborts; the next edge is IDLE with all outputs at 0.
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: result held.
- IDLE or DONE, `start`=1 at an edge:
  - target <= `fn`; `acc` <= 1; `k` <= 1.
  - `done` <= 0; `n` and `exact` cleared.
  - state -> RUN.
- RUN, one step per cycle, checked in this priority order:
  1. `acc >= target`: state -> DONE, `done` <= 1.
     - If `acc == target`: `n` <= `k`, `exact` <= 1.
     - Otherwise: `n` <= `k-1`, `exact` <= 0.
  2. `acc*(k+1)` does not fit in `FN_WIDTH` bits: state -> DONE, `n` <= `k`, `exact` <= 0, `done` <= 1.
  3. Otherwise: `acc` <= `acc*(k+1)` (truncated to `FN_WIDTH` only after the fit check), `k` <= `k+1`.
- Product width: the full product is `FN_WIDTH+N_WIDTH` bits. Overflow means any nonzero bit above `FN_WIDTH`.
- Latency, from the start-sampling edge to `done` high:
  - exact `k!`: `k` cycles.
  - non-exact, not overflowing: `n+1` cycles.
  - overflow termination: `n` cycles.
- DONE:
  - `done`, `n` and `exact` hold until `rst` or a new `start`.
  - A new `start` in DONE drops `done` on that same edge.
- `start` during RUN is ignored. Changes on `fn` after the start edge are ignored.
- Boundaries:
  - `fn`=0: first RUN cycle has `acc`(1) >= 0 -> `n`=0, `exact`=0, latency 1.
  - `fn`=1: `n`=1, `exact`=1, latency 1. Report 1, never 0.
- `k` never wraps. `N_WIDTH` sizing guarantees the overflow termination fires first.

Decomposition:
- Shared header file:
  - state encodings `ST_IDLE`, `ST_RUN`, `ST_DONE` (2-bit).
  - default `N_WIDTH`/`FN_WIDTH` constants, shared with the factorial block.
- One sub-module, `mul_ovf_chk`: a combinational `FN_WIDTH` x `N_WIDTH` multiplier returning the truncated product plus an overflow flag.
- The FSM and registers live in `inv_factorial`.

Test Plan:
- `fn`=3628800 (10!) -> `n`=10, `exact`=1, `done` high 10 cycles after the start edge; `done` stays high until the next `start`.
- `fn`=100 -> `n`=4, `exact`=0, latency 5.
- `fn`=0 -> `n`=0, `exact`=0, latency 1. Then `fn`=1 -> `n`=1, `exact`=1, latency 1.
- `fn`=32'hFFFFFFFF -> overflow termination: `n`=12, `exact`=0, latency 12. Also `fn`=479001600 (12!) -> `n`=12, `exact`=1.
- Start with `fn`=3628800; drive `start`=1 with `fn`=5 on cycle 3; assert `rst` for one cycle on cycle 6:
  - the mid-RUN `start` is ignored;
  - after reset, `done`=`n`=`exact`=0 and state is IDLE;
  - a fresh start with `fn`=24 then gives `n`=4, `exact`=1.
- Round trip with the factorial block: for `n`=1..12, feed its `fn` output here -> same `n` returned, `exact`=1.
